// File: rtl/fetch.sv
// Instruction fetch stage: owns the PC, issues word reads, hands instructions to decode.
// Optional FETCH_ALIGN_CHECK_EN: misaligned redirect targets fault instead of being truncated.
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic        fault,
  output logic [31:0] fault_pc
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] timer, timer_nxt;
  logic [31:0] inst_nxt, inst_pc_nxt, fault_pc_nxt;
  logic        mem_read_nxt, inst_valid_nxt, fault_nxt;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  function automatic logic [31:0] next_word(input logic [31:0] addr);
    return addr + 32'd4;
  endfunction

  function automatic logic timeout_hit(input logic [31:0] cnt);
    return (TIMEOUT != 0) && (cnt == TIMEOUT - 1);
  endfunction

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    timer_nxt    = timer;
    inst_nxt     = inst;
    inst_pc_nxt  = inst_pc;
    fault_pc_nxt = fault_pc;

    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        if (mem_ack) begin
          inst_nxt    = mem_rdata;
          inst_pc_nxt = pc;
          pc_nxt      = next_word(pc);
          timer_nxt   = '0;
          state_nxt   = HOLD;
        end else if (timeout_hit(timer)) begin
          fault_pc_nxt = pc;
          timer_nxt    = '0;
          state_nxt    = FAULT;
        end else begin
          timer_nxt = timer + 32'd1;
        end
      end
      HOLD: begin
        if (inst_ready) state_nxt = REQ;
      end
      FAULT: state_nxt = FAULT;
      default: state_nxt = IDLE;
    endcase

    // Redirect overrides everything; any same-cycle ack data is dropped.
    if (redirect) begin
      timer_nxt   = '0;
      inst_nxt    = inst;
      inst_pc_nxt = inst_pc;
`ifdef FETCH_ALIGN_CHECK_EN
      pc_nxt = redirect_pc;
      if (redirect_pc[1:0] != 2'b00) begin
        fault_pc_nxt = redirect_pc;
        state_nxt    = FAULT;
      end else begin
        state_nxt = REQ;
      end
`else
      pc_nxt    = word_align(redirect_pc);
      state_nxt = REQ;
`endif
    end

    mem_read_nxt   = (state_nxt == REQ);
    inst_valid_nxt = (state_nxt == HOLD);
    fault_nxt      = (state_nxt == FAULT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      timer      <= '0;
      mem_read   <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
      inst_valid <= 1'b0;
      fault      <= 1'b0;
      fault_pc   <= '0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      timer      <= timer_nxt;
      mem_read   <= mem_read_nxt;
      inst       <= inst_nxt;
      inst_pc    <= inst_pc_nxt;
      inst_valid <= inst_valid_nxt;
      fault      <= fault_nxt;
      fault_pc   <= fault_pc_nxt;
    end
  end

  // The PC register doubles as the registered fetch address.
  assign mem_addr = pc;

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: table-driven fetch vectors with a scoreboard queue, plus redirect/timeout/reset sequences.
module tb_fetch;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_addr, mem_rdata, redirect_pc, inst, inst_pc, fault_pc;
  logic        mem_read, mem_ack, redirect, inst_valid, inst_ready, fault;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rdata;
    int          ack_delay;
    int          ready_delay;
    logic [31:0] exp_pc;
  } vec_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } exp_t;

  vec_t vecs[5];
  exp_t exp_q[$];

  fetch #(.RESET_PC(32'h0000_0000), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .fault(fault), .fault_pc(fault_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic pop_compare();
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_underflow got handshake expected none");
    end else begin
      e = exp_q.pop_front();
      chk("sb_inst", inst, e.inst);
      chk("sb_inst_pc", inst_pc, e.pc);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mem_read"}, {31'd0, mem_read}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk({tag, "_inst"}, inst, 32'h0);
    chk({tag, "_inst_pc"}, inst_pc, 32'h0);
    chk({tag, "_inst_valid"}, {31'd0, inst_valid}, 32'd0);
    chk({tag, "_fault"}, {31'd0, fault}, 32'd0);
    chk({tag, "_fault_pc"}, fault_pc, 32'h0);
  endtask

  // Entered at a negedge with the DUT in REQ; leaves at a negedge with the DUT back in REQ.
  task automatic run_vec(input vec_t v);
    chk("req_read", {31'd0, mem_read}, 32'd1);
    chk("req_addr", mem_addr, v.exp_pc);
    repeat (v.ack_delay) begin
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      @(negedge clk);
      chk("wait_read", {31'd0, mem_read}, 32'd1);
      chk("wait_fault", {31'd0, fault}, 32'd0);
    end
    mem_ack   = 1'b1;
    mem_rdata = v.rdata;
    exp_q.push_back('{inst: v.rdata, pc: v.exp_pc});
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    chk("valid_latency", {31'd0, inst_valid}, 32'd1);
    chk("hold_read", {31'd0, mem_read}, 32'd0);
    repeat (v.ready_delay) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, inst_valid}, 32'd1);
      chk("bp_inst", inst, v.rdata);
      chk("bp_inst_pc", inst_pc, v.exp_pc);
      chk("bp_read", {31'd0, mem_read}, 32'd0);
    end
    inst_ready = 1'b1;
    pop_compare();
    @(negedge clk);
    inst_ready = 1'b0;
    chk("post_hs_read", {31'd0, mem_read}, 32'd1);
    chk("post_hs_valid", {31'd0, inst_valid}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{rdata: 32'h0000_0013, ack_delay: 0, ready_delay: 0, exp_pc: 32'h0};
    vecs[1] = '{rdata: 32'h0000_0013, ack_delay: 0, ready_delay: 0, exp_pc: 32'h4};
    vecs[2] = '{rdata: 32'h00A0_0093, ack_delay: 2, ready_delay: 0, exp_pc: 32'h8};
    vecs[3] = '{rdata: 32'h1234_5678, ack_delay: 0, ready_delay: 5, exp_pc: 32'hC};
    vecs[4] = '{rdata: 32'hDEAD_BEEF, ack_delay: 1, ready_delay: 1, exp_pc: 32'h10};

    rst = 1'b1; mem_ack = 1'b0; mem_rdata = 32'h0; redirect = 1'b0;
    redirect_pc = 32'h0; inst_ready = 1'b0;

    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Redirect in REQ with a simultaneous ack: ack data must be dropped.
    redirect = 1'b1; redirect_pc = 32'h100; mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    redirect = 1'b0; mem_ack = 1'b0;
    chk("redir_addr", mem_addr, 32'h100);
    chk("redir_valid", {31'd0, inst_valid}, 32'd0);
    run_vec('{rdata: 32'h0000_0011, ack_delay: 0, ready_delay: 0, exp_pc: 32'h100});

    // Redirect in HOLD together with the handshake of the held instruction.
    mem_ack = 1'b1; mem_rdata = 32'h0000_0022;
    exp_q.push_back('{inst: 32'h0000_0022, pc: 32'h104});
    @(negedge clk);
    mem_ack = 1'b0;
    chk("hold_valid", {31'd0, inst_valid}, 32'd1);
    redirect = 1'b1; redirect_pc = 32'h200; inst_ready = 1'b1;
    pop_compare();
    @(negedge clk);
    redirect = 1'b0; inst_ready = 1'b0;
    chk("hold_redir_read", {31'd0, mem_read}, 32'd1);
    chk("hold_redir_addr", mem_addr, 32'h200);
    chk("hold_redir_valid", {31'd0, inst_valid}, 32'd0);
    run_vec('{rdata: 32'h0000_0033, ack_delay: 0, ready_delay: 0, exp_pc: 32'h200});

    // Misaligned redirect target.
    redirect = 1'b1; redirect_pc = 32'h102;
    @(negedge clk);
    redirect = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    chk("mis_fault", {31'd0, fault}, 32'd1);
    chk("mis_fault_pc", fault_pc, 32'h102);
    chk("mis_read", {31'd0, mem_read}, 32'd0);
    redirect = 1'b1; redirect_pc = 32'h300;
    @(negedge clk);
    redirect = 1'b0;
    chk("mis_recover_fault", {31'd0, fault}, 32'd0);
    run_vec('{rdata: 32'h0000_0044, ack_delay: 0, ready_delay: 0, exp_pc: 32'h300});
`else
    chk("mis_fault", {31'd0, fault}, 32'd0);
    run_vec('{rdata: 32'h0000_0044, ack_delay: 0, ready_delay: 0, exp_pc: 32'h100});
`endif

    // PC wrap at the top of the address space.
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect = 1'b0;
    run_vec('{rdata: 32'h0000_0055, ack_delay: 0, ready_delay: 0, exp_pc: 32'hFFFF_FFFC});
    run_vec('{rdata: 32'h0000_0066, ack_delay: 0, ready_delay: 0, exp_pc: 32'h0});

    // Asynchronous reset in the middle of a request, checked before the next edge.
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;
    chk("idle_read", {31'd0, mem_read}, 32'd0);
    @(negedge clk);
    chk("first_req_read", {31'd0, mem_read}, 32'd1);
    chk("first_req_addr", mem_addr, 32'h0);

    // Timeout: four REQ cycles without ack, then sticky fault.
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk);
      chk("to_pending_fault", {31'd0, fault}, 32'd0);
      chk("to_pending_read", {31'd0, mem_read}, 32'd1);
    end
    @(negedge clk);
    chk("to_fault", {31'd0, fault}, 32'd1);
    chk("to_fault_pc", fault_pc, 32'h0);
    chk("to_read", {31'd0, mem_read}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("to_sticky", {31'd0, fault}, 32'd1);
    chk("to_sticky_valid", {31'd0, inst_valid}, 32'd0);
    redirect = 1'b1; redirect_pc = 32'h40;
    @(negedge clk);
    redirect = 1'b0;
    chk("to_clear", {31'd0, fault}, 32'd0);
    run_vec('{rdata: 32'h0000_0077, ack_delay: 3, ready_delay: 0, exp_pc: 32'h40});
    chk("final_fault", {31'd0, fault}, 32'd0);
    chk("sb_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch.md
# fetch

Instruction fetch stage of the rv core: owns the program counter, issues 32-bit word reads to the memory port, and presents each fetched instruction with its address to the decoder through a valid/ready handshake. It sits directly upstream of decode and directly on the core side of the mem read port. It handles control-flow redirects and a bus-timeout fault.

## Interface
- RESET_PC, 32'h0000_0000: PC loaded on reset; must be word aligned.
- TIMEOUT, 16: cycles in REQ without mem_ack before FAULT; 0 disables the timeout.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high.
- mem_addr  out  32  byte address of the word being fetched.
- mem_read  out  1  read request to memory.
- mem_rdata  in  32  read data, valid when mem_ack=1.
- mem_ack  in  1  read complete this cycle.
- redirect  in  1  load a new PC, sampled on the clock edge.
- redirect_pc  in  32  target PC for redirect.
- inst  out  32  fetched instruction.
- inst_pc  out  32  address of inst.
- inst_valid  out  1  inst/inst_pc valid for decode.
- inst_ready  in  1  decode accepts inst this cycle.
- fault  out  1  fetch stalled on a fault; sticky until redirect.
- fault_pc  out  32  PC of the faulting fetch or redirect.

## Operation
- State machine: IDLE, REQ, HOLD, FAULT.
- Reset values: state=IDLE, pc=RESET_PC, timer=0, mem_read=0, mem_addr=RESET_PC, inst=0, inst_pc=0, inst_valid=0, fault=0, fault_pc=0.
- IDLE: moves unconditionally to REQ on the next edge.
- REQ: mem_read=1 and mem_addr=pc.
  - If mem_ack=1, latch inst=mem_rdata and inst_pc=pc, set pc=pc+4 (modulo 2^32; 32'hFFFF_FFFC wraps to 0), clear timer, and go to HOLD.
  - If mem_ack=0, increment timer. When TIMEOUT!=0 and TIMEOUT consecutive cycles pass without ack, go to FAULT with fault_pc=pc.
- HOLD: inst_valid=1 and mem_read=0. inst and inst_pc stay stable until the handshake. A handshake is inst_valid & inst_ready; on it, go to REQ.
- FAULT: mem_read=0, inst_valid=0, fault=1. The state is held until a redirect.
- Redirect (priority over everything, in any state):
  - Next state is REQ, pc=redirect_pc, inst_valid=0, timer=0, fault=0.
  - A mem_ack in the same cycle is discarded.
  - A simultaneous inst_ready in HOLD completes the handshake for the old instruction; the redirect still applies.
- mem_ack outside REQ is ignored.
- Asserting rst in any state, including mid-request, returns all outputs to their reset values immediately.

## Timing
- In REQ, mem_addr and mem_read are registered outputs.
- mem_ack sampled in cycle N gives inst_valid=1 in cycle N+1.
- A handshake in cycle M gives mem_read=1 in cycle M+1.
- Peak throughput is one instruction per 2 cycles, with same-cycle ack and inst_ready held high.
- First request after reset: mem_read=1 in the second cycle after rst deasserts (IDLE, then REQ).
- Redirect sampled in cycle R gives mem_read=1 with mem_addr=redirect_pc in cycle R+1.
- Timeout: with TIMEOUT=T, fault=1 in the cycle after the T-th consecutive REQ cycle without ack.

## Configuration
- FETCH_ALIGN_CHECK_EN defined: a redirect with redirect_pc[1:0]!=0 goes to FAULT, sets fault_pc=redirect_pc and fault=1 next cycle, and issues no request.
- FETCH_ALIGN_CHECK_EN undefined: redirect_pc[1:0] is forced to 2'b00 and fetch proceeds normally.

## Test plan
- Reset and sequential fetch: with RESET_PC=0, ack returning 32'h0000_0013 each REQ, and inst_ready=1, expect inst_pc 0, 4, 8 on successive valids, each 2 cycles apart.
- Backpressure: hold inst_ready=0 for 5 cycles in HOLD. inst and inst_pc must stay stable, mem_read must stay 0, and only one instruction is delivered.
- Redirect mid-request: redirect to 32'h100 while in REQ with an ack in the same cycle. The ack data is discarded and the next mem_addr=32'h100.
- Timeout and recovery: with TIMEOUT=4 and no ack, fault=1 after 4 REQ cycles with fault_pc=0. A redirect to 32'h40 clears fault and fetches from 32'h40.
- Misaligned redirect to 32'h102:
  - With FETCH_ALIGN_CHECK_EN: fault=1, fault_pc=32'h102, mem_read=0.
  - Without it: the fetch issues to 32'h100.
- Wrap and async reset: redirect to 32'hFFFF_FFFC and ack; the next fetch must be at 0. Pulse rst mid-REQ; all outputs must return to their reset values before the next edge.
